// File: rtl/pokey_timer_pair_pkg.sv
// Shared constants for the POKEY-style timer pair: default width, reset values
// and the independent/joined mode encoding.
package pokey_timer_pair_pkg;

    localparam int WIDTH_DEF    = 8;
    localparam int RST_FREQ_DEF = 0;

    localparam logic RST_BOR  = 1'b0;
    localparam logic RST_TONE = 1'b0;

    typedef enum logic {
        MODE_INDEP = 1'b0,
        MODE_JOIN  = 1'b1
    } mode_e;

endpackage

// File: rtl/pokey_timer_pair_down_counter.sv
// Whole-word down counter used for each timer channel; wraps modulo 2^WIDTH
// unless a load is requested, and load always wins over a tick.
module pokey_down_counter
    import pokey_timer_pair_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enn,
    input  logic             tick,
    input  logic             load,
    input  logic [WIDTH-1:0] ld_val,
    output logic             zero_out,
    output logic             wrap,
    output logic [WIDTH-1:0] cnt
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    assign zero_out = (cnt == '0);
    assign wrap     = tick & zero_out;

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (enn) begin
            if (load) begin
                cnt <= ld_val;
            end else if (tick) begin
                cnt <= cnt - ONE;
            end
        end
    end

endmodule

// File: rtl/pokey_timer_pair.sv
// Pair of down-counting frequency dividers with reload, borrow pulses and
// square-wave tone outputs; optionally cascaded into one 2*WIDTH divider.
module pokey_timer_pair
    import pokey_timer_pair_pkg::*;
#(
    parameter int               WIDTH    = WIDTH_DEF,
    parameter logic [WIDTH-1:0] RST_FREQ = WIDTH'(RST_FREQ_DEF)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enn,
    input  logic             tick_lo,
    input  logic             tick_hi,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_lo,
    input  logic             wr_hi,
    input  logic             restart,
    input  logic             join_mode,
    output logic [WIDTH-1:0] cnt_lo,
    output logic [WIDTH-1:0] cnt_hi,
    output logic             bor_lo,
    output logic             bor_hi,
    output logic             tone_lo,
    output logic             tone_hi
);

    mode_e            mode;
    logic [WIDTH-1:0] freq_lo;
    logic [WIDTH-1:0] freq_hi;
    logic             zero_lo;
    logic             zero_hi;
    logic             wrap_lo;
    logic             wrap_hi;
    logic             tick_hi_sel;
    logic             load_lo;
    logic             load_hi;
    logic             bor_lo_nxt;
    logic             bor_hi_nxt;

    assign mode = mode_e'(join_mode);

    // Joined: the high word only steps when the low word underflows, and the
    // pair reloads together once the whole 2*WIDTH value has reached zero.
    always_comb begin
        tick_hi_sel = tick_hi;
        load_lo     = restart | wrap_lo;
        load_hi     = restart | wrap_hi;
        bor_lo_nxt  = wrap_lo;
        bor_hi_nxt  = wrap_hi;
        if (mode == MODE_JOIN) begin
            tick_hi_sel = tick_lo & zero_lo;
            load_lo     = restart | wrap_hi;
            bor_lo_nxt  = wrap_lo & ~zero_hi;
        end
    end

    pokey_down_counter #(.WIDTH(WIDTH)) u_cnt_lo (
        .clk      (clk),
        .reset    (reset),
        .enn      (enn),
        .tick     (tick_lo),
        .load     (load_lo),
        .ld_val   (freq_lo),
        .zero_out (zero_lo),
        .wrap     (wrap_lo),
        .cnt      (cnt_lo)
    );

    pokey_down_counter #(.WIDTH(WIDTH)) u_cnt_hi (
        .clk      (clk),
        .reset    (reset),
        .enn      (enn),
        .tick     (tick_hi_sel),
        .load     (load_hi),
        .ld_val   (freq_hi),
        .zero_out (zero_hi),
        .wrap     (wrap_hi),
        .cnt      (cnt_hi)
    );

    // A write landing on a reload edge only affects the following reload.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            freq_lo <= RST_FREQ;
            freq_hi <= RST_FREQ;
        end else if (enn) begin
            if (wr_lo) freq_lo <= din;
            if (wr_hi) freq_hi <= din;
        end
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            bor_lo  <= RST_BOR;
            bor_hi  <= RST_BOR;
            tone_lo <= RST_TONE;
            tone_hi <= RST_TONE;
        end else if (enn) begin
            if (restart) begin
                bor_lo <= 1'b0;
                bor_hi <= 1'b0;
            end else begin
                bor_lo  <= bor_lo_nxt;
                bor_hi  <= bor_hi_nxt;
                tone_lo <= tone_lo ^ bor_lo_nxt;
                tone_hi <= tone_hi ^ bor_hi_nxt;
            end
        end
    end

endmodule

// File: tb/tb_pokey_timer_pair.sv
// Directed bench for pokey_timer_pair: an arithmetic reference model is checked
// against the DUT after every falling edge, plus hand-computed pinned values.
module tb_pokey_timer_pair;

    localparam int W   = 8;
    localparam int MOD = 256;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enn = 1'b1;
    logic         tick_lo = 1'b0;
    logic         tick_hi = 1'b0;
    logic [W-1:0] din = '0;
    logic         wr_lo = 1'b0;
    logic         wr_hi = 1'b0;
    logic         restart = 1'b0;
    logic         join_mode = 1'b0;
    logic [W-1:0] cnt_lo;
    logic [W-1:0] cnt_hi;
    logic         bor_lo;
    logic         bor_hi;
    logic         tone_lo;
    logic         tone_hi;

    pokey_timer_pair #(.WIDTH(W), .RST_FREQ('0)) dut (
        .clk       (clk),
        .reset     (reset),
        .enn       (enn),
        .tick_lo   (tick_lo),
        .tick_hi   (tick_hi),
        .din       (din),
        .wr_lo     (wr_lo),
        .wr_hi     (wr_hi),
        .restart   (restart),
        .join_mode (join_mode),
        .cnt_lo    (cnt_lo),
        .cnt_hi    (cnt_hi),
        .bor_lo    (bor_lo),
        .bor_hi    (bor_hi),
        .tone_lo   (tone_lo),
        .tone_hi   (tone_hi)
    );

    always #5 clk = ~clk;

    // Model state: plain integers, joined value handled as one number.
    int m_lo, m_hi, f_lo, f_hi;
    bit b_lo, b_hi, t_lo, t_hi;
    int n_pass = 0;
    int n_total = 0;

    // Pinned expectations, written only by the stimulus process.
    bit pin_en = 0;
    int pin_lo, pin_blo, pin_tlo, pin_hi, pin_bhi, pin_thi;

    task automatic chk(input string nm, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
    endtask

    task automatic model_clear();
        m_lo = 0; m_hi = 0; f_lo = 0; f_hi = 0;
        b_lo = 0; b_hi = 0; t_lo = 0; t_hi = 0;
    endtask

    task automatic model_step();
        int c;
        if (restart) begin
            m_lo = f_lo; m_hi = f_hi; b_lo = 0; b_hi = 0;
        end else if (join_mode) begin
            c = m_hi * MOD + m_lo;
            b_lo = 0; b_hi = 0;
            if (tick_lo) begin
                if (c == 0) begin
                    c = f_hi * MOD + f_lo; b_hi = 1; t_hi = !t_hi;
                end else begin
                    if (c % MOD == 0) begin b_lo = 1; t_lo = !t_lo; end
                    c = c - 1;
                end
            end
            m_hi = c / MOD; m_lo = c % MOD;
        end else begin
            b_lo = 0; b_hi = 0;
            if (tick_lo) begin
                if (m_lo == 0) begin m_lo = f_lo; b_lo = 1; t_lo = !t_lo; end
                else m_lo = m_lo - 1;
            end
            if (tick_hi) begin
                if (m_hi == 0) begin m_hi = f_hi; b_hi = 1; t_hi = !t_hi; end
                else m_hi = m_hi - 1;
            end
        end
        if (wr_lo) f_lo = din;
        if (wr_hi) f_hi = din;
    endtask

    initial model_clear();

    always begin
        @(negedge clk or posedge reset);
        if (reset) model_clear();
        else if (enn) model_step();
        #1;
        chk("cnt_lo", int'(cnt_lo), m_lo);
        chk("cnt_hi", int'(cnt_hi), m_hi);
        chk("bor_lo", int'(bor_lo), int'(b_lo));
        chk("bor_hi", int'(bor_hi), int'(b_hi));
        chk("tone_lo", int'(tone_lo), int'(t_lo));
        chk("tone_hi", int'(tone_hi), int'(t_hi));
        if (pin_en && !reset) begin
            chk("pin_cnt_lo", int'(cnt_lo), pin_lo);
            chk("pin_bor_lo", int'(bor_lo), pin_blo);
            chk("pin_tone_lo", int'(tone_lo), pin_tlo);
            chk("pin_cnt_hi", int'(cnt_hi), pin_hi);
            chk("pin_bor_hi", int'(bor_hi), pin_bhi);
            chk("pin_tone_hi", int'(tone_hi), pin_thi);
            chk("model_cnt_lo", m_lo, pin_lo);
            chk("model_cnt_hi", m_hi, pin_hi);
        end
    end

    // Inputs change 2 time units after a falling edge, well clear of it.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic expect_step(input int lo, input int blo, input int tlo,
                               input int hi, input int bhi, input int thi);
        pin_lo = lo; pin_blo = blo; pin_tlo = tlo;
        pin_hi = hi; pin_bhi = bhi; pin_thi = thi;
        pin_en = 1;
        step(1);
        pin_en = 0;
    endtask

    initial begin
        step(2);
        reset = 1'b0;
        // Program freq_lo=3, freq_hi=1
        din = 8'd3; wr_lo = 1; step(1); wr_lo = 0;
        din = 8'd1; wr_hi = 1; step(1); wr_hi = 0;

        // Independent mode, both channels ticking every edge
        tick_lo = 1; tick_hi = 1;
        expect_step(3, 1, 1, 1, 1, 1);
        step(3);
        expect_step(3, 1, 0, 1, 1, 1);
        step(3);
        expect_step(3, 1, 1, 1, 1, 1);

        // Enable low: everything holds, including bor
        enn = 0;
        step(9);
        expect_step(3, 1, 1, 1, 1, 1);
        enn = 1;
        expect_step(2, 0, 1, 0, 0, 1);
        tick_hi = 0;

        // Write/reload collision on the low channel
        tick_lo = 0; din = 8'd5; wr_lo = 1; step(1); wr_lo = 0;
        tick_lo = 1; step(2);
        din = 8'd9; wr_lo = 1;
        expect_step(5, 1, 0, 0, 0, 1);
        wr_lo = 0;
        step(5);
        expect_step(9, 1, 1, 0, 0, 1);

        // Restart beats tick with cnt_lo at zero
        step(9);
        restart = 1;
        expect_step(9, 0, 1, 1, 0, 1);
        restart = 0;

        // Joined 16-bit divider, freq {1,2}, tick_hi must be ignored
        tick_lo = 0; din = 8'd2; wr_lo = 1; step(1); wr_lo = 0;
        join_mode = 1; restart = 1;
        expect_step(2, 0, 1, 1, 0, 1);
        restart = 0; tick_lo = 1; tick_hi = 1;
        expect_step(1, 0, 1, 1, 0, 1);
        expect_step(0, 0, 1, 1, 0, 1);
        expect_step(255, 1, 0, 0, 0, 1);
        step(254);
        expect_step(0, 0, 0, 0, 0, 1);
        expect_step(2, 0, 0, 1, 1, 0);
        step(5);

        // Back to independent mid-count: no clear, no reload
        join_mode = 0; tick_hi = 0;
        step(6);

        // Async reset mid-count, then restart counting
        #1 reset = 1;
        pin_lo = 0; pin_blo = 0; pin_tlo = 0; pin_hi = 0; pin_bhi = 0; pin_thi = 0;
        #2;
        chk("rst_now_cnt_lo", int'(cnt_lo), 0);
        chk("rst_now_bor_hi", int'(bor_hi), 0);
        step(2);
        reset = 0; tick_lo = 0;
        din = 8'd4; wr_lo = 1; step(1); wr_lo = 0;
        tick_lo = 1;
        expect_step(4, 1, 1, 0, 0, 0);
        expect_step(3, 0, 1, 0, 0, 0);
        tick_lo = 0;
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
